store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Write-side companion to the data memory and load extender in the MEM stage.
- Accepts sb/sh/sw stores from the pipeline and aligns each one into byte lanes with a 4-bit byte enable.
- Holds stores in a small in-order FIFO and drains them to the data-memory write port using a req/ack handshake.
- Forwards buffered store data to younger loads and stalls loads it cannot fully satisfy.

Parameters:
- DEPTH, 4, number of buffered stores; must be a power of two, 2..16.
- AW, 10, word-address width of the data-memory port (1024 words).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low: 0 resets the block on the next clk edge.
- st_valid  in  1  store request.
- st_ready  out  1  buffer can accept a store this cycle.
- st_addr  in  32  byte address (ALU result).
- st_data  in  32  store data (RD2), right-justified.
- st_size  in  2  10=sw, 01=sh, 00=sb, 11=illegal.
- st_misalign  out  1  one-cycle pulse: the offered store was dropped.
- ld_valid  in  1  load in MEM this cycle.
- ld_addr  in  32  load byte address.
- ld_size  in  2  same encoding as st_size.
- ld_hit  out  1  ld_data is valid forwarded data.
- ld_data  out  32  lane-aligned word for the load extender.
- ld_stall  out  1  load must wait.
- mem_req  out  1  write request to data memory.
- mem_ack  in  1  memory accepted the write.
- mem_addr  out  AW  word address, st_addr[AW+1:2].
- mem_wdata  out  32  lane-aligned data.
- mem_be  out  4  byte enables; bit i covers data[8i+7:8i].
- flush  in  1  drain-all request.
- flush_done  out  1  one-cycle pulse when the flush completes.
- count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=0 at a clk edge):
  - count=0; head and tail pointers = 0; state=IDLE.
  - All outputs 0 except st_ready=1.
  - Entries in flight, including an un-acked mem_req, are discarded.
- Alignment (combinational on st_addr[1:0] and st_size):
  - sb: data={4{st_data[7:0]}}, be=4'b0001<<addr[1:0].
  - sh: data={2{st_data[15:0]}}, be = addr[1] ? 1100 : 0011; requires addr[0]=0.
  - sw: data=st_data, be=1111; requires addr[1:0]=00.
  - size 11, or a violated alignment rule: no enqueue, st_misalign=1 for that cycle.
- Enqueue:
  - Occurs on st_valid && st_ready && aligned.
  - The entry {word addr, data, be} is written at the tail; visible to forwarding from the next cycle.
- st_ready:
  - st_ready = (count<DEPTH) && state!=FLUSH.
  - It does not depend on mem_ack. When full, a same-cycle pop does not admit a push.
- Drain:
  - mem_req = (count!=0). mem_addr/mem_wdata/mem_be = head entry, held stable while mem_req && !mem_ack.
  - Pop happens on mem_req && mem_ack; the next head is presented in the following cycle.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- Forwarding (combinational):
  - Match = valid entry with word addr == ld_addr[AW+1:2]. Needed lanes come from the same alignment rule applied to ld_addr and ld_size.
  - Youngest match whose be covers all needed lanes: ld_hit=1, ld_data = that entry's data with non-enabled lanes zeroed.
  - Any match without full cover by the youngest match: ld_stall=1, ld_hit=0.
  - No match: ld_hit=0, ld_stall=0; the load reads memory.
  - A same-cycle enqueue is not visible to forwarding. A same-cycle popping entry still counts as a match.
  - With ld_valid=0, ld_hit and ld_stall are both 0.
- State machine:
  - IDLE: count=0. Goes to DRAIN on enqueue.
  - DRAIN: count>0. Goes to IDLE when the last entry pops with no same-cycle push.
  - flush=1 in any state → FLUSH.
  - FLUSH: st_ready=0 and draining continues. When count=0, flush_done=1 for one cycle, then IDLE.
  - flush with an empty buffer: flush_done is asserted the next cycle.

Decomposition:
- Shared package/define file (alongside ctrl_encode_def.v):
  - size codes BS_W=2'b10, BS_H=2'b01, BS_B=2'b00.
  - state codes SB_IDLE, SB_DRAIN, SB_FLUSH.
- One sub-module, store_lane_align: combinational size/addr → {data, be, misalign}.
  - Instantiated twice: once for stores and once for the load lane-need check.

Test Plan:
- Lane mapping: sb addr 0x13, data 0xAB, mem_ack=1 → mem_addr=4, mem_be=1000, mem_wdata=0xABABABAB. sh addr 0x12, data 0x1234 → be=1100, wdata=0x12341234.
- Misalignment: sw addr 0x21 → st_misalign pulses, count stays 0, mem_req=0. Same for sh addr 0x11 and size 11.
- Full/backpressure: mem_ack=0, 4 sw stores → count=4, st_ready=0. Fifth store held. Release mem_ack for 1 cycle → count=3; heads pop in FIFO order with mem_addr held stable while un-acked.
- Forwarding:
  - sw 0xDEADBEEF @0x40 buffered; lw 0x40 → ld_hit=1, ld_data=0xDEADBEEF.
  - Then sb 0x11 @0x41; lw 0x40 → ld_stall=1.
  - lb 0x41 → ld_hit=1, ld_data=0x00001100.
- Flush: 3 entries, flush=1, mem_ack=1 → st_ready=0 for 3 cycles, flush_done one cycle after the last pop, state IDLE.
- Reset mid-drain: 2 entries with mem_req high, rst=0 one cycle → count=0, mem_req=0, st_ready=1; no write issued after reset.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared encodings for the MEM-stage store buffer: access-size codes,
// controller states and a byte-enable to bit-mask helper.
package store_buffer_pkg;

  localparam logic [1:0] BS_W = 2'b10;
  localparam logic [1:0] BS_H = 2'b01;
  localparam logic [1:0] BS_B = 2'b00;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_DRAIN = 2'd1,
    SB_FLUSH = 2'd2
  } sb_state_e;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store, load-forward, data-memory write and flush signals of the store buffer.
// The pipeline/memory side uses master; the buffer uses slave.
interface store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic          st_ready;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic [1:0]    st_size;
  logic          st_misalign;
  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic [1:0]    ld_size;
  logic          ld_hit;
  logic [31:0]   ld_data;
  logic          ld_stall;
  logic          mem_req;
  logic          mem_ack;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          flush;
  logic          flush_done;
  logic [CW-1:0] count;

  modport master (
    output st_valid, st_addr, st_data, st_size,
    input  st_ready, st_misalign,
    output ld_valid, ld_addr, ld_size,
    input  ld_hit, ld_data, ld_stall,
    input  mem_req, mem_addr, mem_wdata, mem_be,
    output mem_ack,
    output flush,
    input  flush_done, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_size,
    output st_ready, st_misalign,
    input  ld_valid, ld_addr, ld_size,
    output ld_hit, ld_data, ld_stall,
    output mem_req, mem_addr, mem_wdata, mem_be,
    input  mem_ack,
    input  flush,
    output flush_done, count
  );
endinterface

// File: rtl/store_lane_align.sv
// Maps a size code and byte offset onto byte lanes: replicated data, byte
// enables and a misalignment flag (enables cleared when misaligned).
module store_lane_align
  import store_buffer_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic [3:0]  be,
  output logic        misalign
);

  always_comb begin
    data_out = data_in;
    be       = '0;
    misalign = 1'b0;
    case (size)
      BS_B: begin
        data_out = {4{data_in[7:0]}};
        be       = 4'b0001 << addr;
      end
      BS_H: begin
        data_out = {2{data_in[15:0]}};
        be       = addr[1] ? 4'b1100 : 4'b0011;
        misalign = addr[0];
      end
      BS_W: begin
        be       = 4'b1111;
        misalign = (addr != 2'b00);
      end
      default: misalign = 1'b1;
    endcase
    if (misalign) be = '0;
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store FIFO between the pipeline and the data-memory write port,
// with youngest-match load forwarding and a flush/drain controller.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 10
)(
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [3:0]    q_be   [DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_nxt;
  sb_state_e     state;
  logic          flush_done_q;

  logic [31:0]   st_al_data;
  logic [3:0]    st_al_be, ld_need;
  logic          st_mis, ld_mis;
  logic          push, pop;

  store_lane_align u_st_align (
    .addr     (bus.st_addr[1:0]),
    .size     (bus.st_size),
    .data_in  (bus.st_data),
    .data_out (st_al_data),
    .be       (st_al_be),
    .misalign (st_mis)
  );

  store_lane_align u_ld_align (
    .addr     (bus.ld_addr[1:0]),
    .size     (bus.ld_size),
    .data_in  ('0),
    .data_out (),
    .be       (ld_need),
    .misalign (ld_mis)
  );

  assign bus.st_ready    = (count < CW'(DEPTH)) && (state != SB_FLUSH);
  assign bus.st_misalign = bus.st_valid && st_mis;
  assign push            = bus.st_valid && bus.st_ready && !st_mis;
  assign bus.mem_req     = (count != '0);
  assign pop             = bus.mem_req && bus.mem_ack;
  assign count_nxt       = count + CW'(push) - CW'(pop);

  assign bus.mem_addr   = bus.mem_req ? q_addr[head] : '0;
  assign bus.mem_wdata  = bus.mem_req ? q_data[head] : '0;
  assign bus.mem_be     = bus.mem_req ? q_be[head]   : '0;
  assign bus.count      = count;
  assign bus.flush_done = flush_done_q;

  // Walk oldest to youngest so the last hit left standing is the youngest match.
  logic          fwd_match, fwd_cover;
  logic [PW-1:0] fwd_idx, idx;
  always_comb begin
    fwd_match = 1'b0;
    fwd_idx   = '0;
    idx       = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (q_addr[idx] == bus.ld_addr[AW+1:2])) begin
        fwd_match = 1'b1;
        fwd_idx   = idx;
      end
    end
  end

  assign fwd_cover    = ((q_be[fwd_idx] & ld_need) == ld_need);
  assign bus.ld_hit   = bus.ld_valid && !ld_mis && fwd_match && fwd_cover;
  assign bus.ld_stall = bus.ld_valid && !ld_mis && fwd_match && !fwd_cover;
  assign bus.ld_data  = bus.ld_hit ? (q_data[fwd_idx] & lane_mask(q_be[fwd_idx])) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      state        <= SB_IDLE;
      flush_done_q <= 1'b0;
    end else begin
      if (push) begin
        q_addr[tail] <= bus.st_addr[AW+1:2];
        q_data[tail] <= st_al_data;
        q_be[tail]   <= st_al_be;
        tail         <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      count <= count_nxt;

      // flush_done fires on the edge where the buffer empties; FLUSH is left one cycle later.
      flush_done_q <= (bus.flush || (state == SB_FLUSH && !flush_done_q)) && (count_nxt == '0);

      if (bus.flush) begin
        state <= SB_FLUSH;
      end else begin
        case (state)
          SB_IDLE:  if (push) state <= SB_DRAIN;
          SB_DRAIN: if (count_nxt == '0) state <= SB_IDLE;
          SB_FLUSH: if (flush_done_q) state <= SB_IDLE;
          default:  state <= SB_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: lane mapping, misalignment,
// backpressure, forwarding, flush and reset during drain.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(4), .AW(10)) bus ();

  store_buffer #(.DEPTH(4), .AW(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    bus.st_valid = v;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_size  = s;
  endtask

  task automatic set_ld(input logic v, input logic [31:0] a, input logic [1:0] s);
    bus.ld_valid = v;
    bus.ld_addr  = a;
    bus.ld_size  = s;
  endtask

  initial begin
    set_st(1'b0, 32'h0, 32'h0, BS_W);
    set_ld(1'b0, 32'h0, BS_W);
    bus.mem_ack = 1'b0;
    bus.flush   = 1'b0;

    // Reset
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_count",    32'(bus.count), 32'd0);
    chk("rst_st_ready", 32'(bus.st_ready), 32'd1);
    chk("rst_mem_req",  32'(bus.mem_req), 32'd0);
    chk("rst_fdone",    32'(bus.flush_done), 32'd0);
    chk("rst_ld_hit",   32'(bus.ld_hit), 32'd0);
    chk("rst_ld_stall", 32'(bus.ld_stall), 32'd0);

    // Lane mapping, memory always acking
    bus.mem_ack = 1'b1;
    set_st(1'b1, 32'h13, 32'h0000_00AB, BS_B);
    #1;
    chk("sb_misalign", 32'(bus.st_misalign), 32'd0);
    tick();
    set_st(1'b0, 32'h0, 32'h0, BS_W);
    #1;
    chk("sb_count",    32'(bus.count), 32'd1);
    chk("sb_mem_req",  32'(bus.mem_req), 32'd1);
    chk("sb_mem_addr", 32'(bus.mem_addr), 32'd4);
    chk("sb_mem_be",   32'(bus.mem_be), 32'b1000);
    chk("sb_wdata",    bus.mem_wdata, 32'hABAB_ABAB);
    tick();
    chk("sb_popped",   32'(bus.count), 32'd0);
    set_st(1'b1, 32'h12, 32'h0000_1234, BS_H);
    tick();
    set_st(1'b0, 32'h0, 32'h0, BS_W);
    #1;
    chk("sh_mem_addr", 32'(bus.mem_addr), 32'd4);
    chk("sh_mem_be",   32'(bus.mem_be), 32'b1100);
    chk("sh_wdata",    bus.mem_wdata, 32'h1234_1234);
    tick();
    chk("sh_popped",   32'(bus.mem_req), 32'd0);

    // Misaligned / illegal stores are dropped
    set_st(1'b1, 32'h21, 32'h1111_1111, BS_W);
    #1;
    chk("sw_mis_pulse", 32'(bus.st_misalign), 32'd1);
    tick();
    set_st(1'b1, 32'h11, 32'h2222_2222, BS_H);
    #1;
    chk("sw_mis_count", 32'(bus.count), 32'd0);
    chk("sh_mis_pulse", 32'(bus.st_misalign), 32'd1);
    tick();
    set_st(1'b1, 32'h20, 32'h3333_3333, 2'b11);
    #1;
    chk("sz11_pulse", 32'(bus.st_misalign), 32'd1);
    tick();
    set_st(1'b0, 32'h0, 32'h0, BS_W);
    #1;
    chk("mis_count",   32'(bus.count), 32'd0);
    chk("mis_mem_req", 32'(bus.mem_req), 32'd0);
    chk("mis_clear",   32'(bus.st_misalign), 32'd0);

    // Full buffer and backpressure
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_st(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), BS_W);
      tick();
    end
    set_st(1'b1, 32'h110, 32'hA4, BS_W);
    #1;
    chk("full_count", 32'(bus.count), 32'd4);
    chk("full_ready", 32'(bus.st_ready), 32'd0);
    tick();
    chk("held_count", 32'(bus.count), 32'd4);
    chk("held_addr",  32'(bus.mem_addr), 32'h40);
    chk("held_wdata", bus.mem_wdata, 32'hA0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    #1;
    chk("ack1_count", 32'(bus.count), 32'd3);
    chk("ack1_addr",  32'(bus.mem_addr), 32'h41);
    chk("ack1_wdata", bus.mem_wdata, 32'hA1);
    chk("ack1_ready", 32'(bus.st_ready), 32'd1);
    tick();
    set_st(1'b0, 32'h0, 32'h0, BS_W);
    #1;
    chk("fifth_count", 32'(bus.count), 32'd4);
    tick();
    chk("stable_addr", 32'(bus.mem_addr), 32'h41);
    bus.mem_ack = 1'b1;
    for (int i = 2; i < 5; i++) begin
      tick();
      chk("fifo_addr",  32'(bus.mem_addr), 32'h40 + 32'(i));
      chk("fifo_wdata", bus.mem_wdata, 32'hA0 + 32'(i));
    end
    tick();
    chk("drained", 32'(bus.count), 32'd0);

    // Forwarding
    bus.mem_ack = 1'b0;
    set_st(1'b1, 32'h40, 32'hDEAD_BEEF, BS_W);
    set_ld(1'b1, 32'h40, BS_W);
    #1;
    chk("fwd_same_cycle", 32'(bus.ld_hit), 32'd0);
    tick();
    set_st(1'b0, 32'h0, 32'h0, BS_W);
    #1;
    chk("fwd_lw_hit",   32'(bus.ld_hit), 32'd1);
    chk("fwd_lw_data",  bus.ld_data, 32'hDEAD_BEEF);
    chk("fwd_lw_stall", 32'(bus.ld_stall), 32'd0);
    set_st(1'b1, 32'h41, 32'h0000_0011, BS_B);
    tick();
    set_st(1'b0, 32'h0, 32'h0, BS_W);
    #1;
    chk("fwd_partial_stall", 32'(bus.ld_stall), 32'd1);
    chk("fwd_partial_hit",   32'(bus.ld_hit), 32'd0);
    set_ld(1'b1, 32'h41, BS_B);
    #1;
    chk("fwd_lb_hit",  32'(bus.ld_hit), 32'd1);
    chk("fwd_lb_data", bus.ld_data, 32'h0000_1100);
    set_ld(1'b1, 32'h80, BS_W);
    #1;
    chk("fwd_miss_hit",   32'(bus.ld_hit), 32'd0);
    chk("fwd_miss_stall", 32'(bus.ld_stall), 32'd0);
    set_ld(1'b0, 32'h40, BS_W);
    #1;
    chk("fwd_novalid_stall", 32'(bus.ld_stall), 32'd0);
    set_ld(1'b1, 32'h40, BS_H);
    bus.mem_ack = 1'b1;
    #1;
    chk("fwd_popping_stall", 32'(bus.ld_stall), 32'd1);
    tick();
    set_ld(1'b0, 32'h0, BS_W);
    tick();
    chk("fwd_drained", 32'(bus.count), 32'd0);

    // Flush with three entries
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_st(1'b1, 32'h200 + 32'(4 * i), 32'hC0 + 32'(i), BS_W);
      tick();
    end
    set_st(1'b0, 32'h0, 32'h0, BS_W);
    #1;
    chk("fl_count", 32'(bus.count), 32'd3);
    bus.mem_ack = 1'b1;
    bus.flush   = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    chk("fl_ready0", 32'(bus.st_ready), 32'd0);
    chk("fl_fdone0", 32'(bus.flush_done), 32'd0);
    tick();
    chk("fl_ready1", 32'(bus.st_ready), 32'd0);
    chk("fl_count1", 32'(bus.count), 32'd1);
    tick();
    chk("fl_ready2", 32'(bus.st_ready), 32'd0);
    chk("fl_fdone2", 32'(bus.flush_done), 32'd1);
    chk("fl_empty",  32'(bus.count), 32'd0);
    tick();
    chk("fl_fdone3", 32'(bus.flush_done), 32'd0);
    chk("fl_idle",   32'(bus.st_ready), 32'd1);

    // Flush while empty
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    chk("fe_fdone", 32'(bus.flush_done), 32'd1);
    tick();
    chk("fe_fdone_clear", 32'(bus.flush_done), 32'd0);
    chk("fe_ready",       32'(bus.st_ready), 32'd1);

    // Reset during drain
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_st(1'b1, 32'h300 + 32'(4 * i), 32'hE0 + 32'(i), BS_W);
      tick();
    end
    set_st(1'b0, 32'h0, 32'h0, BS_W);
    #1;
    chk("rd_mem_req", 32'(bus.mem_req), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rd_count",    32'(bus.count), 32'd0);
    chk("rd_mem_req0", 32'(bus.mem_req), 32'd0);
    chk("rd_ready",    32'(bus.st_ready), 32'd1);
    bus.mem_ack = 1'b1;
    tick();
    chk("rd_no_write", 32'(bus.mem_req), 32'd0);
    chk("rd_mem_be",   32'(bus.mem_be), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
